// File: rtl/axi4_lite_rd_arbiter.sv
// Two-requester to one-completer AXI4-Lite read arbiter.
// Requests are granted round-robin and issued downstream one at a time through a
// registered AR stage. A 1-bit tag FIFO remembers which requester owns each
// outstanding read, so every R beat is steered back to the requester that issued
// the matching AR.
module axi4_lite_rd_arbiter #(
    parameter int A = 32,
    parameter int N = 4,
    parameter int D = 4
) (
    input  logic             aclk,
    input  logic             areset,

    input  logic [A-1:0]     s0_araddr,
    input  logic             s0_arvalid,
    output logic             s0_arready,
    output logic [8*N-1:0]   s0_rdata,
    output logic [1:0]       s0_rresp,
    output logic             s0_rvalid,
    input  logic             s0_rready,

    input  logic [A-1:0]     s1_araddr,
    input  logic             s1_arvalid,
    output logic             s1_arready,
    output logic [8*N-1:0]   s1_rdata,
    output logic [1:0]       s1_rresp,
    output logic             s1_rvalid,
    input  logic             s1_rready,

    output logic [A-1:0]     m_araddr,
    output logic             m_arvalid,
    input  logic             m_arready,
    input  logic [8*N-1:0]   m_rdata,
    input  logic [1:0]       m_rresp,
    input  logic             m_rvalid,
    output logic             m_rready,

    output logic             busy
);

    localparam int PW = $clog2(D);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] D_CNT = CW'(D);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [D-1:0]      tag_reg;
    logic [D-1:0]      tag_we;
    logic              last_grant_reg, last_grant_next;
    logic [A-1:0]      m_araddr_reg, m_araddr_next;
    logic              m_arvalid_reg, m_arvalid_next;

    logic              grant_sel;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              head;

    assign fifo_empty = (cnt_reg == '0);
    assign head       = tag_reg[rd_ptr_reg];
    assign pop        = m_rvalid & m_rready;

    // AR arbitration and issue: grant decision, requester ready and next AR stage
    always_comb begin
        state_next      = state_reg;
        m_araddr_next   = m_araddr_reg;
        m_arvalid_next  = m_arvalid_reg;
        last_grant_next = last_grant_reg;
        push            = 1'b0;
        s0_arready      = 1'b0;
        s1_arready      = 1'b0;
        // On a tie the requester that did not win last time goes next.
        if (s0_arvalid && s1_arvalid) begin
            grant_sel = ~last_grant_reg;
        end else begin
            grant_sel = s1_arvalid;
        end
        case (state_reg)
            IDLE: begin
                // The registered count gates the grant, so a same-cycle pop does
                // not open a slot until the following cycle.
                if (!areset && (s0_arvalid || s1_arvalid) && (cnt_reg < D_CNT)) begin
                    push            = 1'b1;
                    s0_arready      = ~grant_sel;
                    s1_arready      = grant_sel;
                    m_araddr_next   = grant_sel ? s1_araddr : s0_araddr;
                    m_arvalid_next  = 1'b1;
                    last_grant_next = grant_sel;
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                if (m_arready) begin
                    m_arvalid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outstanding-read count: push on grant, pop on accepted R beat
    always_comb begin
        cnt_next = cnt_reg;
        case ({push, pop})
            2'b10:   cnt_next = cnt_reg + CW'(1);
            2'b01:   cnt_next = cnt_reg - CW'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    // Per-entry write enables for the tag FIFO
    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_tag_we
            assign tag_we[gi] = push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // State, AR output stage, round-robin pointer and outstanding count
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg      <= IDLE;
            m_araddr_reg   <= '0;
            m_arvalid_reg  <= 1'b0;
            last_grant_reg <= 1'b1;
            cnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            m_araddr_reg   <= m_araddr_next;
            m_arvalid_reg  <= m_arvalid_next;
            last_grant_reg <= last_grant_next;
            cnt_reg        <= cnt_next;
        end
    end

    // Tag FIFO storage and wrapping read/write pointers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tag_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            for (int i = 0; i < D; i++) begin
                if (tag_we[i]) begin
                    tag_reg[i] <= grant_sel;
                end
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

    assign m_araddr  = m_araddr_reg;
    assign m_arvalid = m_arvalid_reg;

    // R steering: only the FIFO head's requester sees rvalid; data fans out to both
    assign s0_rvalid = m_rvalid & ~fifo_empty & ~head;
    assign s1_rvalid = m_rvalid & ~fifo_empty &  head;
    assign m_rready  = ~fifo_empty & (head ? s1_rready : s0_rready);
    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s1_rresp  = m_rresp;

    assign busy = ~fifo_empty | (state_reg == ISSUE);

endmodule
